// File: rtl/seg_pkg.sv
// Shared constants for the six-digit multiplexed 7-segment display bus.
// Used by both the display driver and the receive-side decoder.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment patterns, bit7 = dp (off), bits6:0 = g..a
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [5:0] SEL_S0 = 6'b111110;
  localparam logic [5:0] SEL_S1 = 6'b111101;
  localparam logic [5:0] SEL_M0 = 6'b111011;
  localparam logic [5:0] SEL_M1 = 6'b110111;
  localparam logic [5:0] SEL_H0 = 6'b101111;
  localparam logic [5:0] SEL_H1 = 6'b011111;

  typedef enum logic [1:0] {SEEK, SETTLE, HOLD} state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } sel_dec_t;

  function automatic sel_dec_t decode_sel(input logic [5:0] sel);
    sel_dec_t d;
    d = '{valid: 1'b1, idx: 3'd0};
    case (sel)
      SEL_S0:  d.idx = 3'd0;
      SEL_S1:  d.idx = 3'd1;
      SEL_M0:  d.idx = 3'd2;
      SEL_M1:  d.idx = 3'd3;
      SEL_H0:  d.idx = 3'd4;
      SEL_H1:  d.idx = 3'd5;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low 7-segment pattern (g..a) to BCD.
// Anything outside the ten digit glyphs is reported as not legal.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal
);

  always_comb begin
    bcd   = 4'd0;
    legal = 1'b1;
    case (seg)
      SEG_0[6:0]: bcd = 4'd0;
      SEG_1[6:0]: bcd = 4'd1;
      SEG_2[6:0]: bcd = 4'd2;
      SEG_3[6:0]: bcd = 4'd3;
      SEG_4[6:0]: bcd = 4'd4;
      SEG_5[6:0]: bcd = 4'd5;
      SEG_6[6:0]: bcd = 4'd6;
      SEG_7[6:0]: bcd = 4'd7;
      SEG_8[6:0]: bcd = 4'd8;
      SEG_9[6:0]: bcd = 4'd9;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Display-bus monitor: recovers six BCD digits from a scanned sel/seg bus
// and publishes them once every digit has been captured in the current frame.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            sel_in,
  input  logic [7:0]            seg_in,
  output logic [3:0]            s0,
  output logic [3:0]            s1,
  output logic [3:0]            m0,
  output logic [3:0]            m1,
  output logic [3:0]            h0,
  output logic [3:0]            h1,
  output logic [NUM_DIGITS-1:0] digit_err,
  output logic                  frame_valid
);

  localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [NUM_DIGITS-1:0] MASK_FULL   = '1;

  logic [5:0] sel_p0, sel_p1, sel_p2;
  logic [7:0] seg_p0, seg_p1;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     capture;
  sel_dec_t                 dec;
  logic                     sel_chg;
  logic [3:0]               bcd;
  logic                     legal;
  logic [NUM_DIGITS-1:0]    mask, mask_nxt, err_sh;
  logic [NUM_DIGITS-1:0][3:0] shadow, digits;

  // Stage p0/p1: two-flop synchronizer; p2 keeps the previous synced sel for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_p0 <= '1;
      sel_p1 <= '1;
      sel_p2 <= '1;
      seg_p0 <= '1;
      seg_p1 <= '1;
    end else begin
      sel_p0 <= sel_in;
      sel_p1 <= sel_p0;
      sel_p2 <= sel_p1;
      seg_p0 <= seg_in;
      seg_p1 <= seg_p0;
    end
  end

  assign dec     = decode_sel(sel_p1);
  assign sel_chg = (sel_p1 != sel_p2);

  seg7_to_bcd u_dec (
    .seg   (seg_p1[6:0]),
    .bcd   (bcd),
    .legal (legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEEK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      SEEK: begin
        cnt_nxt = '0;
        if (dec.valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (sel_chg) begin
          cnt_nxt   = '0;
          state_nxt = dec.valid ? SETTLE : SEEK;
        end else if (cnt == SETTLE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        cnt_nxt = '0;
        if (sel_chg) state_nxt = dec.valid ? SETTLE : SEEK;
      end
      default: begin
        state_nxt = SEEK;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    capture = (state == SETTLE) && !sel_chg && (cnt == SETTLE_LAST);
  end

  // A full mask is published and cleared on the cycle after the completing capture
  always_comb begin
    mask_nxt = (mask == MASK_FULL) ? '0 : mask;
    if (capture) mask_nxt = mask_nxt | (NUM_DIGITS'(1) << dec.idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask        <= '0;
      shadow      <= '0;
      err_sh      <= '0;
      digits      <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      mask        <= mask_nxt;
      frame_valid <= (mask == MASK_FULL);
      if (capture) begin
        if (legal) begin
          shadow[dec.idx] <= bcd;
          err_sh[dec.idx] <= 1'b0;
        end else begin
          err_sh[dec.idx] <= 1'b1;
        end
      end
      if (mask == MASK_FULL) begin
        digits    <= shadow;
        digit_err <= err_sh;
      end
    end
  end

  assign s0 = digits[0];
  assign s1 = digits[1];
  assign m0 = digits[2];
  assign m1 = digits[3];
  assign h0 = digits[4];
  assign h1 = digits[5];

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized scoreboard bench for seg_scan_decoder: a frame-level model
// predicts each published frame; a monitor compares on every frame_valid.
module tb_seg_scan_decoder;

  localparam int SC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] sel_in = 6'h3F;
  logic [7:0] seg_in = 8'hFF;
  logic [3:0] s0, s1, m0, m1, h0, h1;
  logic [5:0] digit_err;
  logic       frame_valid;

  seg_scan_decoder #(.SETTLE_CYC(SC), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .sel_in(sel_in), .seg_in(seg_in),
    .s0(s0), .s1(s1), .m0(m0), .m1(m1), .h0(h0), .h1(h1),
    .digit_err(digit_err), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       d[6];
    bit [5:0] e;
  } frame_t;

  frame_t     exp_q[$];
  int         m_shadow[6];
  bit   [5:0] m_err;
  bit   [5:0] m_mask;
  logic [7:0] pat[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [5:0] last_sel = 6'h3F;
  int         tests = 0;
  int         fails = 0;
  int         frames_seen = 0;
  int         frames_pushed = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int glyph_value(input logic [7:0] seg);
    logic [7:0] p;
    for (int i = 0; i < 10; i++) begin
      p = pat[i];
      if (p[6:0] == seg[6:0]) return i;
    end
    return -1;
  endfunction

  function automatic int sel_index(input logic [5:0] sel);
    int n = 0, idx = -1;
    for (int i = 0; i < 6; i++) if (!sel[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_shadow[i] = 0;
    m_err  = '0;
    m_mask = '0;
    exp_q.delete();
  endtask

  // A digit is captured once its select has been held long enough; the sixth distinct one completes a frame
  task automatic model_capture(input int idx, input logic [7:0] seg);
    frame_t f;
    int v = glyph_value(seg);
    if (v >= 0) begin m_shadow[idx] = v; m_err[idx] = 1'b0; end
    else m_err[idx] = 1'b1;
    m_mask[idx] = 1'b1;
    if (m_mask == 6'h3F) begin
      f.d = m_shadow;
      f.e = m_err;
      exp_q.push_back(f);
      frames_pushed++;
      m_mask = '0;
    end
  endtask

  task automatic dwell(input logic [5:0] sel, input logic [7:0] seg, input int n);
    int idx;
    if (sel == last_sel && sel_index(sel) >= 0) begin
      #1 sel_in = 6'h3F; seg_in = 8'hFF;
      repeat (3) @(posedge clk);
    end
    idx = sel_index(sel);
    if (idx >= 0 && n >= SC + 2) model_capture(idx, seg);
    #1 sel_in = sel; seg_in = seg;
    last_sel = sel;
    repeat (n) @(posedge clk);
  endtask

  task automatic scan(input int d[6], input int n);
    for (int i = 5; i >= 0; i--) dwell(~(6'b1 << i), pat[d[i]], n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s0"}, s0, 0);  check({tag, "_s1"}, s1, 0);
    check({tag, "_m0"}, m0, 0);  check({tag, "_m1"}, m1, 0);
    check({tag, "_h0"}, h0, 0);  check({tag, "_h1"}, h1, 0);
    check({tag, "_err"}, digit_err, 0);
  endtask

  task automatic do_reset();
    dwell(6'h3F, 8'hFF, 10);
    #1 rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check({"rst_fv"}, frame_valid, 0);
    check_zero("rst");
    rst = 1'b0;
    last_sel = 6'h3F;
  endtask

  always @(negedge clk) begin
    frame_t f;
    if (!rst && frame_valid) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        check("frame_unexpected", 1, 0);
      end else begin
        f = exp_q.pop_front();
        check("s0", s0, f.d[0]);  check("s1", s1, f.d[1]);
        check("m0", m0, f.d[2]);  check("m1", m1, f.d[3]);
        check("h0", h0, f.d[4]);  check("h1", h1, f.d[5]);
        check("digit_err", digit_err, f.e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_1234[6];
    int rd[6];
    int idx, n;
    logic [7:0] sg;
    model_reset();
    t_1234 = '{6, 5, 4, 3, 2, 1};

    // Reset and idle bus
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;
    dwell(6'h3F, 8'hFF, 100);
    check_zero("idle");
    check("idle_frames", frames_seen, 0);

    // Clean scan of 12:34:56
    scan(t_1234, 40);
    dwell(6'h3F, 8'hFF, 10);
    check("frame_1234", frames_seen, 1);

    // s0 dwell one short of the settle time: no frame
    for (int i = 5; i >= 1; i--) dwell(~(6'b1 << i), pat[t_1234[i]], 40);
    dwell(6'b111110, pat[6], SC - 1);
    dwell(6'h3F, 8'hFF, 10);
    check("short_s0_frames", frames_seen, 1);

    // Blank pattern on m0 flags an error and keeps the old m0
    for (int i = 5; i >= 0; i--) dwell(~(6'b1 << i), (i == 2) ? 8'hFF : pat[t_1234[i]], 40);
    dwell(6'h3F, 8'hFF, 10);
    check("blank_m0_frames", frames_seen, 2);

    // Two selects low: ignored, then a clean scan still works
    dwell(6'b111100, pat[8], 50);
    scan(t_1234, 30);
    dwell(6'h3F, 8'hFF, 10);
    check("dual_sel_frames", frames_seen, 3);

    // Reset after three captures loses the partial frame
    for (int i = 5; i >= 3; i--) dwell(~(6'b1 << i), pat[7], 30);
    do_reset();
    scan('{9, 8, 7, 0, 5, 3}, 30);
    dwell(6'h3F, 8'hFF, 10);
    check("post_reset_frames", frames_seen, 4);

    // Randomized scanning
    for (int k = 0; k < 60; k++) begin
      idx = $urandom_range(0, 5);
      if ($urandom_range(0, 9) < 8) sg = {1'($urandom_range(0, 1)), 7'(pat[$urandom_range(0, 9)])};
      else begin
        sg = 8'($urandom);
        while (glyph_value(sg) >= 0) sg = 8'($urandom);
      end
      n = ($urandom_range(0, 9) < 7) ? $urandom_range(SC + 3, SC + 30) : $urandom_range(2, SC - 1);
      if ($urandom_range(0, 9) == 0) dwell(6'b110011, sg, $urandom_range(3, 20));
      dwell(~(6'b1 << idx), sg, n);
    end
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) rd[i] = $urandom_range(0, 9);
      scan(rd, $urandom_range(SC + 3, SC + 20));
    end
    dwell(6'h3F, 8'hFF, 30);

    check("queue_drained", exp_q.size(), 0);
    check("frame_count", frames_seen, frames_pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
